// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory block.
// Holds the control FSM state encoding and the default NOP fill bit.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // Default NOP is this bit replicated across the instruction width.
    localparam logic NOP_DEFAULT_BIT = 1'b0;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: one write port, registered read, optional even parity.
// Parity storage/check is built only when INST_MEM_PARITY_EN is defined.
module inst_mem_array
    import inst_mem_pkg::*;
#(
    parameter int              A   = 10,
    parameter int              W   = 9,
    parameter logic [W-1:0]    NOP = {W{NOP_DEFAULT_BIT}}
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         i_wr_en,
    input  logic [A-1:0] i_wr_addr,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    input  logic [A-1:0] i_rd_addr,
    input  logic         i_rd_oor,
    output logic [W-1:0] o_rd_data,
    output logic         o_par_err
);

    localparam int DEPTH = 2 ** A;

    logic [W-1:0] r_mem [0:DEPTH-1];
    logic [W-1:0] r_rd_data;

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge Clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_rd_data <= NOP;
        end else if (i_rd_en) begin
            r_rd_data <= i_rd_oor ? NOP : r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

`ifdef INST_MEM_PARITY_EN
    logic r_par [0:DEPTH-1];
    logic r_par_err;

    always_ff @(posedge Clk) begin
        if (i_wr_en) begin
            r_par[i_wr_addr] <= ^i_wr_data;
        end
    end

    // Even parity: data XOR stored bit must reduce to zero.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_par_err <= 1'b0;
        end else if (i_rd_en) begin
            r_par_err <= !i_rd_oor && ((^r_mem[i_rd_addr]) != r_par[i_rd_addr]);
        end
    end

    assign o_par_err = r_par_err;
`else
    assign o_par_err = 1'b0;
`endif

endmodule

// File: rtl/inst_mem.sv
// Instruction memory with streaming program loader and registered fetch port.
// Optional parity checking is enabled by defining INST_MEM_PARITY_EN.
module inst_mem
    import inst_mem_pkg::*;
#(
    parameter int              A   = 10,
    parameter int              W   = 9,
    parameter logic [W-1:0]    NOP = {W{NOP_DEFAULT_BIT}}
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         LoadStart,
    input  logic         LoadValid,
    input  logic [W-1:0] LoadData,
    input  logic         LoadLast,
    output logic         LoadReady,
    output logic         Loaded,
    output logic [A:0]   LoadCount,
    input  logic         FetchEn,
    input  logic [A-1:0] InstAddress,
    output logic [W-1:0] InstOut,
    output logic         InstValid,
    output logic         OutOfRange,
    output logic         ParityErr
);

    localparam logic [A:0] CNT_ONE = (A+1)'(1);

    state_t       r_state;
    state_t       w_state_next;
    logic [A:0]   r_count;
    logic         r_inst_valid;
    logic         r_oor;
    logic         w_accept;
    logic         w_last_addr;
    logic         w_fetch;
    logic         w_oor;

    // LoadStart wins over a simultaneous word transfer.
    assign w_accept    = (r_state == ST_LOAD) && LoadValid && !LoadStart;
    assign w_last_addr = (r_count[A-1:0] == {A{1'b1}});
    assign w_fetch     = (r_state == ST_READY) && FetchEn && !LoadStart;
    assign w_oor       = ({1'b0, InstAddress} >= r_count);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (LoadStart) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (LoadStart) begin
                    w_state_next = ST_LOAD;
                end else if (w_accept && (LoadLast || w_last_addr)) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (LoadStart) w_state_next = ST_LOAD;
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= ST_EMPTY;
            r_count      <= '0;
            r_inst_valid <= 1'b0;
            r_oor        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (LoadStart) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + CNT_ONE;
            end
            if (w_state_next != ST_READY) begin
                r_inst_valid <= 1'b0;
            end else if (w_fetch) begin
                r_inst_valid <= 1'b1;
            end
            if (w_fetch) begin
                r_oor <= w_oor;
            end
        end
    end

    inst_mem_array #(
        .A   (A),
        .W   (W),
        .NOP (NOP)
    ) u_array (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_count[A-1:0]),
        .i_wr_data (LoadData),
        .i_rd_en   (w_fetch),
        .i_rd_addr (InstAddress),
        .i_rd_oor  (w_oor),
        .o_rd_data (InstOut),
        .o_par_err (ParityErr)
    );

    assign LoadReady  = (r_state == ST_LOAD);
    assign Loaded     = (r_state == ST_READY);
    assign LoadCount  = r_count;
    assign InstValid  = r_inst_valid;
    assign OutOfRange = r_oor;

endmodule
